taus88_rng: RTL and testbench

- Combined three-component Tausworthe PRNG (L'Ecuyer taus88) producing one 32-bit pseudo-random word per clock.
- "Optimized" variant: a full generator step (all three components plus output XOR) completes in a single cycle with no pipeline.
- Used as a stochastic-computing random source. Components S2/S3 run freely; S1 can be re-seeded at run time.

---
 rtl/taus88_pkg.sv | 31 +++
 rtl/taus88_rng_component.sv | 26 ++
 rtl/taus88_rng.sv | 62 ++++++
 tb/tb_taus88_rng.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/taus88_pkg.sv
// taus88_pkg: shared constants and types for the taus88 combined Tausworthe
// generator.
//   word_t      - 32-bit generator word
//   MASK_1..3   - per-component masks applied before the K shift
//   Q_n/S_n/K_n - per-component shift triples
//   DEF_S1..3   - default component seeds (S2 must be > 7, S3 > 15)
package taus88_pkg;

  typedef logic [31:0] word_t;

  localparam word_t MASK_1 = 32'hFFFF_FFFE;
  localparam word_t MASK_2 = 32'hFFFF_FFF8;
  localparam word_t MASK_3 = 32'hFFFF_FFF0;

  localparam int Q_1 = 13;
  localparam int S_1 = 19;
  localparam int K_1 = 12;

  localparam int Q_2 = 2;
  localparam int S_2 = 25;
  localparam int K_2 = 4;

  localparam int Q_3 = 3;
  localparam int S_3 = 11;
  localparam int K_3 = 17;

  localparam word_t DEF_SEED_1 = 32'd12345;
  localparam word_t DEF_SEED_2 = 32'd12345;
  localparam word_t DEF_SEED_3 = 32'd12345;

endpackage

// File: rtl/taus88_rng_component.sv
// taus_component: one combinational Tausworthe step.
//   y = ((x & MASK) << K) ^ (((x << Q) ^ x) >> S)
// All shifts are logical and the result is truncated to 32 bits.
// Ports:
//   x - current component state
//   y - next component state
module taus_component
  import taus88_pkg::*;
#(
  parameter int    Q    = 13,
  parameter int    S    = 19,
  parameter int    K    = 12,
  parameter word_t MASK = 32'hFFFF_FFFE
) (
  input  word_t x,
  output word_t y
);

  word_t masked_shift;
  word_t feedback;

  assign masked_shift = (x & MASK) << K;
  assign feedback     = ((x << Q) ^ x) >> S;
  assign y            = masked_shift ^ feedback;

endmodule

// File: rtl/taus88_rng.sv
// taus88_rng: single-cycle combined three-component Tausworthe PRNG.
// One new 32-bit word per clock; no enable, no handshake.
// Ports:
//   clk     - clock, all state updates on the rising edge
//   rst     - synchronous active-high reset (highest priority)
//   seed    - replacement S1 value, used when re_seed is high
//   re_seed - load seed into S1 this cycle (S2/S3 keep advancing)
//   rnd     - registered random word: XOR of the newly stored state
module taus88_rng
  import taus88_pkg::*;
#(
  parameter word_t DEF_S1 = DEF_SEED_1,
  parameter word_t DEF_S2 = DEF_SEED_2,
  parameter word_t DEF_S3 = DEF_SEED_3
) (
  input  logic  clk,
  input  logic  rst,
  input  word_t seed,
  input  logic  re_seed,
  output word_t rnd
);

  word_t s1, s2, s3;
  word_t t1_next, t2_next, t3_next;
  word_t seed_ok;
  word_t s1_next;

  taus_component #(.Q(Q_1), .S(S_1), .K(K_1), .MASK(MASK_1)) u_comp1 (
    .x (s1),
    .y (t1_next)
  );

  taus_component #(.Q(Q_2), .S(S_2), .K(K_2), .MASK(MASK_2)) u_comp2 (
    .x (s2),
    .y (t2_next)
  );

  taus_component #(.Q(Q_3), .S(S_3), .K(K_3), .MASK(MASK_3)) u_comp3 (
    .x (s3),
    .y (t3_next)
  );

  // S1 values 0 and 1 collapse the first component to a fixed point once
  // masked, so they are replaced with the default seed.
  assign seed_ok = (seed[31:1] != 31'd0) ? seed : DEF_S1;
  assign s1_next = re_seed ? seed_ok : t1_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= DEF_S1;
      s2  <= DEF_S2;
      s3  <= DEF_S3;
      rnd <= '0;
    end else begin
      s1  <= s1_next;
      s2  <= t2_next;
      s3  <= t3_next;
      rnd <= s1_next ^ t2_next ^ t3_next;
    end
  end

endmodule

// File: tb/tb_taus88_rng.sv
// tb_taus88_rng: self-checking bench for taus88_rng with a reference model
// and an expected-value queue of {rnd, s1, s2, s3}.
module tb_taus88_rng;
  import taus88_pkg::*;

  localparam int W = 128;

  // ---------------- clock / reset ----------------
  logic  clk = 1'b0;
  logic  rst = 1'b1;
  word_t seed = '0;
  logic  re_seed = 1'b0;
  word_t rnd;

  always #5 clk = ~clk;

  taus88_rng dut (
    .clk     (clk),
    .rst     (rst),
    .seed    (seed),
    .re_seed (re_seed),
    .rnd     (rnd)
  );

  // Standalone component instances for unit checks.
  word_t ux1, ux2, ux3, uy1, uy2, uy3;
  taus_component #(.Q(13), .S(19), .K(12), .MASK(32'hFFFF_FFFE)) u_t1 (.x(ux1), .y(uy1));
  taus_component #(.Q(2),  .S(25), .K(4),  .MASK(32'hFFFF_FFF8)) u_t2 (.x(ux2), .y(uy2));
  taus_component #(.Q(3),  .S(11), .K(17), .MASK(32'hFFFF_FFF0)) u_t3 (.x(ux3), .y(uy3));

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  word_t m1, m2, m3;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference step functions written straight from the recurrence.
  function automatic word_t ref_t1(input word_t x);
    word_t a, b;
    a = {x[19:1], 1'b0, 12'd0};
    b = (x ^ (x << 13)) >> 19;
    return a ^ b;
  endfunction

  function automatic word_t ref_t2(input word_t x);
    word_t a, b;
    a = {x[27:3], 3'd0, 4'd0};
    b = (x ^ (x << 2)) >> 25;
    return a ^ b;
  endfunction

  function automatic word_t ref_t3(input word_t x);
    word_t a, b;
    a = {x[14:4], 4'd0, 17'd0};
    b = (x ^ (x << 3)) >> 11;
    return a ^ b;
  endfunction

  // ---------------- driver ----------------
  // Drive one cycle, update the model, push expectation, then compare.
  task automatic step(input logic r, input logic rs, input word_t sd);
    word_t exp_rnd;
    logic [W-1:0] e;
    rst = r;
    re_seed = rs;
    seed = sd;
    if (r) begin
      m1 = 32'd12345; m2 = 32'd12345; m3 = 32'd12345;
      exp_rnd = '0;
    end else begin
      m1 = rs ? ((sd > 32'd1) ? sd : 32'd12345) : ref_t1(m1);
      m2 = ref_t2(m2);
      m3 = ref_t3(m3);
      exp_rnd = m1 ^ m2 ^ m3;
    end
    exp_q.push_back({exp_rnd, m1, m2, m3});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("rnd", rnd,     e[127:96]);
    check("s1",  dut.s1,  e[95:64]);
    check("s2",  dut.s2,  e[63:32]);
    check("s3",  dut.s3,  e[31:0]);
  endtask

  task automatic free_run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    word_t prev;
    int    diffs;

    // Component unit checks.
    ux1 = 32'hDEAD_BEEF; ux2 = 32'h0000_3039; ux3 = 32'h0000_3039;
    #1;
    check("unit_t1", uy1, 32'hDBEE_ED2E);
    check("unit_t2", uy2, 32'h0003_0380);
    check("unit_t3", uy3, 32'h6060_0036);
    check("model_t1", ref_t1(32'hDEAD_BEEF), 32'hDBEE_ED2E);

    // Reset, then first released cycle against known constants.
    step(1'b1, 1'b0, '0);
    check("rnd_in_reset", rnd, 32'h0);
    step(1'b0, 1'b0, '0);
    check("first_rnd", rnd,    32'h6360_8376);
    check("first_s1",  dut.s1, 32'h0303_80C0);
    check("first_s2",  dut.s2, 32'h0003_0380);
    check("first_s3",  dut.s3, 32'h6060_0036);

    // Free run, single-cycle reseed, then ten more.
    free_run(9);
    step(1'b0, 1'b1, 32'hDEAD_BEEF);
    check("reseed_s1", dut.s1, 32'hDEAD_BEEF);
    free_run(10);

    // Invalid seeds substitute the default; output keeps moving.
    step(1'b0, 1'b1, 32'h0);
    check("seed0_s1", dut.s1, 32'd12345);
    free_run(3);
    step(1'b0, 1'b1, 32'h1);
    check("seed1_s1", dut.s1, 32'd12345);
    diffs = 0;
    for (int i = 0; i < 8; i++) begin
      prev = rnd;
      step(1'b0, 1'b0, '0);
      if (rnd != prev) diffs++;
    end
    check("no_lock", 32'(diffs), 32'd8);

    // Reset while re_seed is high mid-run: must replay the first scenario.
    step(1'b0, 1'b1, 32'h1234_5678);
    step(1'b1, 1'b1, 32'h1234_5678);
    check("rst_rs_rnd", rnd,    32'h0);
    check("rst_rs_s1",  dut.s1, 32'd12345);
    step(1'b0, 1'b0, '0);
    check("replay_first", rnd, 32'h6360_8376);

    // re_seed held three cycles.
    free_run(4);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 32'hCAFE_BABE);
      check("hold_s1", dut.s1, 32'hCAFE_BABE);
    end
    free_run(10);

    // Random mix of reseeds (including 0/1) and occasional reset.
    for (int i = 0; i < 200; i++) begin
      int sel;
      word_t sd;
      sel = $urandom_range(0, 19);
      sd  = (sel == 1) ? 32'($urandom_range(0, 1)) : $urandom;
      step(sel == 0, sel <= 4, sd);
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
